mem_prototype: RTL and testbench

MEM_PROTOTYPE -- requirements
Module: mem_prototype

---
 rtl/mem_prototype_pkg.sv | 56 +++++
 rtl/negacyclic_acc.sv | 25 ++
 rtl/mem_prototype.sv | 132 +++++++++++++
 tb/tb_mem_prototype.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_prototype_pkg.sv
// Shared constants, FSM state encoding and mod-251 helpers for mem_prototype.
package mem_prototype_pkg;

   localparam int N  = 512;   // coefficients per polynomial
   localparam int W  = 8;     // bits per coefficient
   localparam int Q  = 251;   // coefficient modulus
   localparam int H  = 256;   // entries per sign in r
   localparam int RW = 9;     // bits per position entry

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // (s + c) mod 251 for s, c in 0..250: 9-bit sum, one conditional -251.
   function automatic logic [W-1:0] mod_add(input logic [W-1:0] s, input logic [W-1:0] c);
      logic [8:0] t;
      t = {1'b0, s} + {1'b0, c};
      if (t >= 9'd251) begin
         t = t - 9'd251;
      end else begin
         t = t;
      end
      return t[W-1:0];
   endfunction

   // (s - c) mod 251 for s, c in 0..250: 9-bit difference, +251 on borrow.
   function automatic logic [W-1:0] mod_sub(input logic [W-1:0] s, input logic [W-1:0] c);
      logic [8:0] t;
      t = {1'b0, s} - {1'b0, c};
      if (t[8]) begin
         t = t + 9'd251;
      end else begin
         t = t;
      end
      return t[W-1:0];
   endfunction

   // Bring every coefficient of a into 0..250 (raw values 251..255 lose 251).
   function automatic logic [N*W-1:0] reduce_poly(input logic [N*W-1:0] a);
      logic [N*W-1:0] r;
      logic [W-1:0]   c;
      for (int k = 0; k < N; k++) begin
         c = a[k*W +: W];
         if (c >= 8'd251) begin
            r[k*W +: W] = c - 8'd251;
         end else begin
            r[k*W +: W] = c;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/negacyclic_acc.sv
// One 512-lane shift-and-modadd bank: nxt = acc + a * x^p mod (x^512 + 1, 251).
// Lanes with k < p receive the wrapped coefficient and therefore subtract.
module negacyclic_acc
   import mem_prototype_pkg::*;
(
   input  logic [N*W-1:0] a,
   input  logic [RW-1:0]  p,
   input  logic [N*W-1:0] acc,
   output logic [N*W-1:0] nxt
);

   for (genvar k = 0; k < N; k++) begin : g_lane
      logic [RW-1:0] idx_s;
      logic [W-1:0]  coef_s;
      logic          wrap_s;

      // 9-bit subtraction gives (k - p) mod 512, which is the source lane in both cases
      assign idx_s  = RW'(k) - p;
      assign coef_s = a[{idx_s, 3'b000} +: W];
      assign wrap_s = (RW'(k) < p);
      assign nxt[k*W +: W] = wrap_s ? mod_sub(acc[k*W +: W], coef_s)
                                    : mod_add(acc[k*W +: W], coef_s);
   end

endmodule

// File: rtl/mem_prototype.sv
// Sparse ternary times dense polynomial in Z_251[x]/(x^512+1), split into the
// +1 sum and the -1 sum. Starts by itself on the first edge after reset release.
// Build option: define MEM_PROTOTYPE_DUAL_ACC_EN to process one +1 and one -1
// entry per cycle with two banks; otherwise a single bank walks all 512 entries.
module mem_prototype
   import mem_prototype_pkg::*;
(
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic [N*W-1:0]  i_poly_a,
   input  logic [N*RW-1:0] i_poly_r,
   output logic [N*W-1:0]  o_sum_one,
   output logic [N*W-1:0]  o_sum_mone,
   output logic            o_done
);

   state_t          state_r, state_nx;
   logic [8:0]      cnt_r;
   logic [N*W-1:0]  a_r;
   logic [N*RW-1:0] r_r;
   logic [N*W-1:0]  one_r, mone_r;
   logic            done_r;
   logic            cap_s, acc_s, last_s;

`ifdef MEM_PROTOTYPE_DUAL_ACC_EN
   logic [N*W-1:0]  nxt_one_s, nxt_mone_s;

   assign last_s = (cnt_r == 9'd255);

   negacyclic_acc u_acc_one (
      .a   (a_r),
      .p   (r_r[13'(cnt_r) * 13'd9 +: RW]),
      .acc (one_r),
      .nxt (nxt_one_s)
   );

   negacyclic_acc u_acc_mone (
      .a   (a_r),
      .p   (r_r[(13'(cnt_r) + 13'd256) * 13'd9 +: RW]),
      .acc (mone_r),
      .nxt (nxt_mone_s)
   );
`else
   logic [N*W-1:0]  nxt_s;

   assign last_s = (cnt_r == 9'd511);

   // Entries 256..511 (counter MSB set) belong to the -1 sum
   negacyclic_acc u_acc (
      .a   (a_r),
      .p   (r_r[13'(cnt_r) * 13'd9 +: RW]),
      .acc (cnt_r[8] ? mone_r : one_r),
      .nxt (nxt_s)
   );
`endif

   // State register
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Next state and datapath enables; entry 0 is accumulated during LOAD
   always_comb begin
      state_nx = state_r;
      cap_s    = 1'b0;
      acc_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cap_s    = 1'b1;
            state_nx = ST_LOAD;
         end
         ST_LOAD: begin
            acc_s    = 1'b1;
            state_nx = ST_RUN;
         end
         ST_RUN: begin
            acc_s = 1'b1;
            if (last_s) begin
               state_nx = ST_DONE;
            end else begin
               state_nx = ST_RUN;
            end
         end
         ST_DONE: begin
            state_nx = ST_DONE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Operand capture, entry counter, accumulators and done flag
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         a_r    <= '0;
         r_r    <= '0;
         cnt_r  <= 9'd0;
         one_r  <= '0;
         mone_r <= '0;
         done_r <= 1'b0;
      end else begin
         if (cap_s) begin
            a_r <= reduce_poly(i_poly_a);
            r_r <= i_poly_r;
         end
         if (acc_s) begin
            cnt_r <= cnt_r + 9'd1;
`ifdef MEM_PROTOTYPE_DUAL_ACC_EN
            one_r  <= nxt_one_s;
            mone_r <= nxt_mone_s;
`else
            if (cnt_r[8]) begin
               mone_r <= nxt_s;
            end else begin
               one_r <= nxt_s;
            end
`endif
         end
         done_r <= (state_r == ST_DONE);
      end
   end

   assign o_sum_one  = one_r;
   assign o_sum_mone = mone_r;
   assign o_done     = done_r;

endmodule

// File: tb/tb_mem_prototype.sv
// Self-checking bench for mem_prototype: directed scenarios plus randomized
// runs compared against a polynomial-product reference model.
module tb_mem_prototype;

   logic          i_clock = 1'b0;
   logic          i_reset;
   logic [4095:0] i_poly_a;
   logic [4607:0] i_poly_r;
   logic [4095:0] o_sum_one;
   logic [4095:0] o_sum_mone;
   logic          o_done;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;

`ifdef MEM_PROTOTYPE_DUAL_ACC_EN
   localparam int EXP_CYC = 258;
`else
   localparam int EXP_CYC = 514;
`endif

   mem_prototype dut (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_poly_a   (i_poly_a),
      .i_poly_r   (i_poly_r),
      .o_sum_one  (o_sum_one),
      .o_sum_mone (o_sum_mone),
      .o_done     (o_done)
   );

   always #5 i_clock = ~i_clock;

   // Index of the first differing coefficient, -1 when equal
   function automatic int first_diff(input logic [4095:0] x, input logic [4095:0] y);
      for (int k = 0; k < 512; k++) begin
         if (x[k*8 +: 8] !== y[k*8 +: 8]) return k;
      end
      return -1;
   endfunction

   // a * (sum of x^p over the chosen half of r), as a negacyclic polynomial product
   function automatic logic [4095:0] model(input logic [4095:0] av, input logic [4607:0] rv,
                                           input int half);
      int mult[512];
      int s[512];
      logic [4095:0] res;
      int p, t, v;
      for (int i = 0; i < 512; i++) begin
         mult[i] = 0;
         s[i] = 0;
      end
      for (int m = 0; m < 256; m++) begin
         p = int'(rv[(half*256 + m)*9 +: 9]);
         mult[p] = mult[p] + 1;
      end
      for (int pp = 0; pp < 512; pp++) begin
         if (mult[pp] != 0) begin
            for (int i = 0; i < 512; i++) begin
               v = (int'(av[i*8 +: 8]) % 251) * mult[pp];
               t = i + pp;
               if (t < 512) s[t] = s[t] + v;
               else s[t-512] = s[t-512] - v;
            end
         end
      end
      for (int k = 0; k < 512; k++) res[k*8 +: 8] = 8'(((s[k] % 251) + 251) % 251);
      return res;
   endfunction

   task automatic hold_reset();
      @(negedge i_clock);
      i_reset = 1'b0;
      repeat (2) @(negedge i_clock);
   endtask

   task automatic release_reset();
      @(negedge i_clock);
      i_reset = 1'b1;
      cyc = 0;
   endtask

   // Count rising edges until o_done, bounded
   task automatic wait_done();
      while (cyc < 2000) begin
         @(posedge i_clock);
         #1;
         cyc++;
         if (o_done === 1'b1) break;
      end
   endtask

   task automatic rand_inputs(input bit full_range);
      for (int k = 0; k < 512; k++)
         i_poly_a[k*8 +: 8] = full_range ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 250));
      for (int m = 0; m < 512; m++) i_poly_r[m*9 +: 9] = 9'($urandom_range(0, 511));
      i_poly_r[0*9 +: 9]   = 9'd0;
      i_poly_r[1*9 +: 9]   = 9'd511;
      i_poly_r[2*9 +: 9]   = 9'd511;
      i_poly_r[256*9 +: 9] = 9'd511;
      i_poly_r[257*9 +: 9] = 9'd0;
   endtask

   task automatic test_reset();
      i_reset = 1'b0;
      rand_inputs(1'b0);
      repeat (2) @(negedge i_clock);
      n_checks++;
      if (o_done !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_done: got %b expected 0", o_done);
      end
      n_checks++;
      if (o_sum_one !== '0) begin
         n_errors++;
         $display("FAIL reset_sum_one: coeff %0d not zero", first_diff(o_sum_one, '0));
      end
      n_checks++;
      if (o_sum_mone !== '0) begin
         n_errors++;
         $display("FAIL reset_sum_mone: coeff %0d not zero", first_diff(o_sum_mone, '0));
      end
   endtask

   task automatic test_zero();
      int d1, d2;
      hold_reset();
      i_poly_a = '0;
      rand_inputs(1'b0);
      i_poly_a = '0;
      release_reset();
      wait_done();
      n_checks++;
      if (cyc != EXP_CYC || o_done !== 1'b1) begin
         n_errors++;
         $display("FAIL zero_latency: got %0d cycles expected %0d", cyc, EXP_CYC);
      end
      d1 = first_diff(o_sum_one, '0);
      d2 = first_diff(o_sum_mone, '0);
      n_checks++;
      if (d1 >= 0) begin
         n_errors++;
         $display("FAIL zero_sum_one: coeff %0d got %0d expected 0", d1, o_sum_one[d1*8 +: 8]);
      end
      n_checks++;
      if (d2 >= 0) begin
         n_errors++;
         $display("FAIL zero_sum_mone: coeff %0d got %0d expected 0", d2, o_sum_mone[d2*8 +: 8]);
      end
   endtask

   task automatic test_shift();
      logic [4095:0] e1, e2;
      int d1, d2;
      hold_reset();
      for (int k = 0; k < 512; k++) i_poly_a[k*8 +: 8] = 8'(k % 251);
      for (int m = 0; m < 512; m++) i_poly_r[m*9 +: 9] = (m < 256) ? 9'd0 : 9'd1;
      for (int k = 0; k < 512; k++) begin
         e1[k*8 +: 8] = 8'((5 * (k % 251)) % 251);
         if (k == 0) e2[k*8 +: 8] = 8'((256 * (251 - (511 % 251))) % 251);
         else e2[k*8 +: 8] = 8'((5 * ((k - 1) % 251)) % 251);
      end
      release_reset();
      wait_done();
      n_checks++;
      if (cyc != EXP_CYC || o_done !== 1'b1) begin
         n_errors++;
         $display("FAIL shift_latency: got %0d cycles expected %0d", cyc, EXP_CYC);
      end
      d1 = first_diff(o_sum_one, e1);
      d2 = first_diff(o_sum_mone, e2);
      n_checks++;
      if (d1 >= 0) begin
         n_errors++;
         $display("FAIL shift_sum_one: coeff %0d got %0d expected %0d", d1,
                  o_sum_one[d1*8 +: 8], e1[d1*8 +: 8]);
      end
      n_checks++;
      if (d2 >= 0) begin
         n_errors++;
         $display("FAIL shift_sum_mone: coeff %0d got %0d expected %0d", d2,
                  o_sum_mone[d2*8 +: 8], e2[d2*8 +: 8]);
      end
   endtask

   task automatic test_wrap();
      logic [4095:0] e;
      int d1, d2;
      hold_reset();
      i_poly_a = '0;
      i_poly_a[511*8 +: 8] = 8'd1;
      for (int m = 0; m < 512; m++) i_poly_r[m*9 +: 9] = 9'd1;
      e = '0;
      e[7:0] = 8'd246;
      release_reset();
      wait_done();
      n_checks++;
      if (cyc != EXP_CYC || o_done !== 1'b1) begin
         n_errors++;
         $display("FAIL wrap_latency: got %0d cycles expected %0d", cyc, EXP_CYC);
      end
      d1 = first_diff(o_sum_one, e);
      d2 = first_diff(o_sum_mone, e);
      n_checks++;
      if (d1 >= 0) begin
         n_errors++;
         $display("FAIL wrap_sum_one: coeff %0d got %0d expected %0d", d1,
                  o_sum_one[d1*8 +: 8], e[d1*8 +: 8]);
      end
      n_checks++;
      if (d2 >= 0) begin
         n_errors++;
         $display("FAIL wrap_sum_mone: coeff %0d got %0d expected %0d", d2,
                  o_sum_mone[d2*8 +: 8], e[d2*8 +: 8]);
      end
   endtask

   task automatic test_random();
      logic [4095:0] e1, e2;
      int d1, d2;
      for (int it = 0; it < 3; it++) begin
         hold_reset();
         rand_inputs(it == 2);
         e1 = model(i_poly_a, i_poly_r, 0);
         e2 = model(i_poly_a, i_poly_r, 1);
         release_reset();
         wait_done();
         n_checks++;
         if (cyc != EXP_CYC || o_done !== 1'b1) begin
            n_errors++;
            $display("FAIL random_latency: iter %0d got %0d cycles expected %0d", it, cyc, EXP_CYC);
         end
         repeat (3) @(posedge i_clock);
         #1;
         d1 = first_diff(o_sum_one, e1);
         d2 = first_diff(o_sum_mone, e2);
         n_checks++;
         if (d1 >= 0) begin
            n_errors++;
            $display("FAIL random_sum_one: iter %0d coeff %0d got %0d expected %0d", it, d1,
                     o_sum_one[d1*8 +: 8], e1[d1*8 +: 8]);
         end
         n_checks++;
         if (d2 >= 0) begin
            n_errors++;
            $display("FAIL random_sum_mone: iter %0d coeff %0d got %0d expected %0d", it, d2,
                     o_sum_mone[d2*8 +: 8], e2[d2*8 +: 8]);
         end
         n_checks++;
         if (o_done !== 1'b1) begin
            n_errors++;
            $display("FAIL random_done_hold: iter %0d got %b expected 1", it, o_done);
         end
      end
   endtask

   task automatic test_abort();
      logic [4095:0] e1, e2;
      int d1, d2, early;
      hold_reset();
      rand_inputs(1'b0);
      release_reset();
      early = 0;
      repeat (100) begin
         @(posedge i_clock);
         #1;
         if (o_done !== 1'b0) early++;
      end
      n_checks++;
      if (early != 0) begin
         n_errors++;
         $display("FAIL abort_done_low: done high on %0d cycles expected 0", early);
      end
      #2;
      i_reset = 1'b0;
      #1;
      n_checks++;
      if (o_sum_one !== '0 || o_sum_mone !== '0 || o_done !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_clear: done %b one coeff %0d mone coeff %0d nonzero", o_done,
                  first_diff(o_sum_one, '0), first_diff(o_sum_mone, '0));
      end
      rand_inputs(1'b0);
      e1 = model(i_poly_a, i_poly_r, 0);
      e2 = model(i_poly_a, i_poly_r, 1);
      repeat (2) @(negedge i_clock);
      release_reset();
      wait_done();
      n_checks++;
      if (cyc != EXP_CYC || o_done !== 1'b1) begin
         n_errors++;
         $display("FAIL abort_latency: got %0d cycles expected %0d", cyc, EXP_CYC);
      end
      d1 = first_diff(o_sum_one, e1);
      d2 = first_diff(o_sum_mone, e2);
      n_checks++;
      if (d1 >= 0 || d2 >= 0) begin
         n_errors++;
         $display("FAIL abort_result: first bad coeff one %0d mone %0d", d1, d2);
      end
   endtask

   task automatic test_input_change();
      logic [4095:0] e1, e2;
      int d1, d2;
      hold_reset();
      rand_inputs(1'b0);
      e1 = model(i_poly_a, i_poly_r, 0);
      e2 = model(i_poly_a, i_poly_r, 1);
      release_reset();
      repeat (3) begin
         @(posedge i_clock);
         #1;
         cyc++;
      end
      rand_inputs(1'b1);
      wait_done();
      n_checks++;
      if (cyc != EXP_CYC || o_done !== 1'b1) begin
         n_errors++;
         $display("FAIL change_latency: got %0d cycles expected %0d", cyc, EXP_CYC);
      end
      d1 = first_diff(o_sum_one, e1);
      d2 = first_diff(o_sum_mone, e2);
      n_checks++;
      if (d1 >= 0) begin
         n_errors++;
         $display("FAIL change_sum_one: coeff %0d got %0d expected %0d", d1,
                  o_sum_one[d1*8 +: 8], e1[d1*8 +: 8]);
      end
      n_checks++;
      if (d2 >= 0) begin
         n_errors++;
         $display("FAIL change_sum_mone: coeff %0d got %0d expected %0d", d2,
                  o_sum_mone[d2*8 +: 8], e2[d2*8 +: 8]);
      end
   endtask

   initial begin
      i_reset  = 1'b0;
      i_poly_a = '0;
      i_poly_r = '0;
      test_reset();
      test_zero();
      test_shift();
      test_wrap();
      test_random();
      test_abort();
      test_input_change();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
